// File: rtl/pancham_step_sequencer_if.sv
// pancham_step_sequencer_if: block intake, round-unit operand and digest handshake bundle
interface pancham_step_sequencer_if;
  logic [511:0] msg_in;
  logic [127:0] chain_in;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  rnd_a;
  logic [31:0]  rnd_b;
  logic [31:0]  rnd_c;
  logic [31:0]  rnd_d;
  logic [31:0]  rnd_m;
  logic [31:0]  rnd_s;
  logic [31:0]  rnd_t;
  logic [1:0]   rnd_round;
  logic [31:0]  rnd_next_a;
  logic [127:0] digest_out;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;
  modport slave (
    input  msg_in, chain_in, msg_valid, rnd_next_a, digest_ready,
    output msg_ready, rnd_a, rnd_b, rnd_c, rnd_d, rnd_m, rnd_s, rnd_t, rnd_round,
           digest_out, digest_valid, busy
  );
  modport master (
    output msg_in, chain_in, msg_valid, rnd_next_a, digest_ready,
    input  msg_ready, rnd_a, rnd_b, rnd_c, rnd_d, rnd_m, rnd_s, rnd_t, rnd_round,
           digest_out, digest_valid, busy
  );
endinterface

// File: rtl/pancham_step_sequencer.sv
// pancham_step_sequencer: sequences one MD5 step per cycle through an external round unit
module pancham_step_sequencer (
  input logic                     clk,
  input logic                     reset_n,
  pancham_step_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [31:0] t_tab [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam logic [4:0] s_tab [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };
  state_t       state;
  logic [5:0]   step;
  logic [31:0]  a, b, c, d;
  logic [511:0] msg_r;
  logic [127:0] chain_r;
  logic [3:0]   k;
  logic         in_round;
  assign in_round = state == ROUND;
  // message word index; 4-bit arithmetic gives the mod-16 wrap for free
  assign k = step[5:4] == 2'd0 ? step[3:0] :
             step[5:4] == 2'd1 ? step[3:0] * 4'd5 + 4'd1 :
             step[5:4] == 2'd2 ? step[3:0] * 4'd3 + 4'd5 :
                                 step[3:0] * 4'd7;
  assign bus.rnd_a     = a;
  assign bus.rnd_b     = b;
  assign bus.rnd_c     = c;
  assign bus.rnd_d     = d;
  assign bus.rnd_round = step[5:4];
  assign bus.rnd_m     = in_round ? msg_r[{k, 5'd0} +: 32] : '0;
  assign bus.rnd_s     = in_round ? {27'd0, s_tab[{step[5:4], step[1:0]}]} : '0;
  assign bus.rnd_t     = in_round ? t_tab[step] : '0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      step             <= '0;
      {d, c, b, a}     <= '0;
      msg_r            <= '0;
      chain_r          <= '0;
      bus.digest_out   <= '0;
      bus.digest_valid <= 1'b0;
      bus.msg_ready    <= 1'b1;
      bus.busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.msg_valid) begin
          msg_r         <= bus.msg_in;
          chain_r       <= bus.chain_in;
          {d, c, b, a}  <= bus.chain_in;
          step          <= '0;
          state         <= ROUND;
          bus.msg_ready <= 1'b0;
          bus.busy      <= 1'b1;
        end
        ROUND: begin
          {a, b, c, d} <= {d, bus.rnd_next_a, b, c};
          step         <= step + 6'd1;
          state        <= step == 6'd63 ? FINAL : ROUND;
        end
        FINAL: begin
          bus.digest_out   <= {chain_r[127:96] + d, chain_r[95:64] + c,
                               chain_r[63:32] + b, chain_r[31:0] + a};
          bus.digest_valid <= 1'b1;
          state            <= DONE;
        end
        DONE: if (bus.digest_ready) begin
          bus.digest_valid <= 1'b0;
          bus.msg_ready    <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pancham_step_sequencer.sv
// tb_pancham_step_sequencer: randomized and known-vector checks against an MD5 reference model
module tb_pancham_step_sequencer;
  localparam logic [127:0] iv      = 128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] dig_emp = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] dig_abc = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [511:0] abc_blk;
  logic [31:0] ru_f, ru_sum;
  logic [63:0] ru_rot;
  always #5 clk = ~clk;
  pancham_step_sequencer_if bus();
  pancham_step_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // external round unit: b + rotl(a + F(b,c,d) + m + t, s)
  always_comb begin
    ru_f = bus.rnd_round == 2'd0 ? (bus.rnd_b & bus.rnd_c) | (~bus.rnd_b & bus.rnd_d) :
           bus.rnd_round == 2'd1 ? (bus.rnd_b & bus.rnd_d) | (bus.rnd_c & ~bus.rnd_d) :
           bus.rnd_round == 2'd2 ? bus.rnd_b ^ bus.rnd_c ^ bus.rnd_d :
                                   bus.rnd_c ^ (bus.rnd_b | ~bus.rnd_d);
    ru_sum = bus.rnd_a + ru_f + bus.rnd_m + bus.rnd_t;
    ru_rot = {ru_sum, ru_sum} << bus.rnd_s[4:0];
    bus.rnd_next_a = bus.rnd_b + ru_rot[63:32];
  end
  function automatic logic [31:0] t_of(int i);
    real v;
    v = $sin(real'(i + 1));
    if (v < 0.0) v = -v;
    return 32'(longint'($floor(v * 4294967296.0)));
  endfunction
  function automatic int s_of(int i);
    int tbl [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    return tbl[(i / 16) * 4 + i % 4];
  endfunction
  function automatic int k_of(int i);
    case (i / 16)
      0: return i;
      1: return (5 * i + 1) % 16;
      2: return (3 * i + 5) % 16;
      default: return (7 * i) % 16;
    endcase
  endfunction
  function automatic logic [127:0] md5_ref(logic [511:0] blk, logic [127:0] chain);
    logic [31:0] a, b, c, d, f, x, tmp;
    int s;
    a = chain[31:0]; b = chain[63:32]; c = chain[95:64]; d = chain[127:96];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: f = (b & c) | (~b & d);
        1: f = (b & d) | (c & ~d);
        2: f = b ^ c ^ d;
        default: f = c ^ (b | ~d);
      endcase
      x = a + f + t_of(i) + blk[32 * k_of(i) +: 32];
      s = s_of(i);
      tmp = d; d = c; c = b;
      b = b + ((x << s) | (x >> (32 - s)));
      a = tmp;
    end
    return {chain[127:96] + d, chain[95:64] + c, chain[63:32] + b, chain[31:0] + a};
  endfunction
  function automatic logic [511:0] rand_blk();
    logic [511:0] m;
    for (int w = 0; w < 16; w++) m[32 * w +: 32] = $urandom;
    return m;
  endfunction
  task automatic wait_digest(output logic [127:0] dig, output int lat);
    lat = 0;
    while (!bus.digest_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.digest_valid) lat = -1;
    dig = bus.digest_out;
    bus.digest_ready = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
  endtask
  task automatic send_block(input logic [511:0] m, input logic [127:0] ch,
                            output logic [127:0] dig, output int lat);
    bus.msg_in = m; bus.chain_in = ch; bus.msg_valid = 1'b1;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    wait_digest(dig, lat);
  endtask
  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy_async: got %b want 0", bus.busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    checks++; if (bus.msg_ready !== 1'b1) begin failures++; $display("FAIL reset_msg_ready: got %b want 1", bus.msg_ready); end
    checks++; if (bus.digest_valid !== 1'b0) begin failures++; $display("FAIL reset_digest_valid: got %b want 0", bus.digest_valid); end
    checks++; if (bus.digest_out !== '0) begin failures++; $display("FAIL reset_digest_out: got %h want 0", bus.digest_out); end
    checks++; if ({bus.rnd_m, bus.rnd_s, bus.rnd_t} !== '0) begin failures++; $display("FAIL reset_rnd_mst: got %h want 0", {bus.rnd_m, bus.rnd_s, bus.rnd_t}); end
    checks++; if ({bus.rnd_a, bus.rnd_b, bus.rnd_c, bus.rnd_d, bus.rnd_round} !== '0) begin failures++; $display("FAIL reset_work_regs: got %h want 0", {bus.rnd_a, bus.rnd_b, bus.rnd_c, bus.rnd_d}); end
  endtask
  task automatic test_vectors();
    logic [127:0] dig;
    int lat;
    send_block(512'h80, iv, dig, lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL empty_latency: got %0d want 65", lat); end
    checks++; if (dig !== dig_emp) begin failures++; $display("FAIL empty_digest: got %h want %h", dig, dig_emp); end
    send_block(abc_blk, iv, dig, lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL abc_latency: got %0d want 65", lat); end
    checks++; if (dig !== dig_abc) begin failures++; $display("FAIL abc_digest: got %h want %h", dig, dig_abc); end
  endtask
  task automatic test_steps();
    logic [511:0] m;
    logic [127:0] ch;
    m = rand_blk();
    ch = {$urandom, $urandom, $urandom, $urandom};
    bus.msg_in = m; bus.chain_in = ch; bus.msg_valid = 1'b1;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    checks++; if ({bus.rnd_d, bus.rnd_c, bus.rnd_b, bus.rnd_a} !== ch) begin failures++; $display("FAIL step0_load: got %h want %h", {bus.rnd_d, bus.rnd_c, bus.rnd_b, bus.rnd_a}, ch); end
    for (int j = 0; j < 64; j++) begin
      checks++; if (bus.rnd_round !== 2'(j / 16)) begin failures++; $display("FAIL step%0d_round: got %0d want %0d", j, bus.rnd_round, j / 16); end
      checks++; if (bus.rnd_s !== 32'(s_of(j))) begin failures++; $display("FAIL step%0d_s: got %0d want %0d", j, bus.rnd_s, s_of(j)); end
      checks++; if (bus.rnd_t !== t_of(j)) begin failures++; $display("FAIL step%0d_t: got %h want %h", j, bus.rnd_t, t_of(j)); end
      checks++; if (bus.rnd_m !== m[32 * k_of(j) +: 32]) begin failures++; $display("FAIL step%0d_m: got %h want %h", j, bus.rnd_m, m[32 * k_of(j) +: 32]); end
      if (j == 17) begin
        checks++; if ({bus.rnd_s, bus.rnd_t, bus.rnd_m} !== {32'd9, 32'hc040b340, m[6 * 32 +: 32]}) begin failures++; $display("FAIL step17_const: got s=%0d t=%h m=%h want s=9 t=c040b340 m=%h", bus.rnd_s, bus.rnd_t, bus.rnd_m, m[6 * 32 +: 32]); end
      end
      checks++; if (bus.busy !== 1'b1 || bus.msg_ready !== 1'b0) begin failures++; $display("FAIL step%0d_busy: got busy=%b ready=%b want 1/0", j, bus.busy, bus.msg_ready); end
      @(posedge clk); #1;
    end
    checks++; if ({bus.rnd_m, bus.rnd_s, bus.rnd_t} !== '0) begin failures++; $display("FAIL final_rnd_zero: got %h want 0", {bus.rnd_m, bus.rnd_s, bus.rnd_t}); end
    @(posedge clk); #1;
    checks++; if (bus.digest_valid !== 1'b1) begin failures++; $display("FAIL steps_valid: got %b want 1", bus.digest_valid); end
    checks++; if (bus.digest_out !== md5_ref(m, ch)) begin failures++; $display("FAIL steps_digest: got %h want %h", bus.digest_out, md5_ref(m, ch)); end
    bus.digest_ready = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
  endtask
  task automatic test_hold();
    int n;
    bus.msg_in = abc_blk; bus.chain_in = iv; bus.msg_valid = 1'b1;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    n = 0;
    while (!bus.digest_valid && n < 200) begin
      bus.msg_in = rand_blk();
      bus.msg_valid = n % 7 == 3;
      checks++; if (bus.msg_ready !== 1'b0) begin failures++; $display("FAIL hold_busy_ready: got %b want 0", bus.msg_ready); end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 65) begin failures++; $display("FAIL hold_latency: got %0d want 65", n); end
    for (int j = 0; j < 10; j++) begin
      bus.msg_valid = j[0];
      checks++; if (bus.digest_valid !== 1'b1 || bus.msg_ready !== 1'b0) begin failures++; $display("FAIL hold_valid%0d: got valid=%b ready=%b want 1/0", j, bus.digest_valid, bus.msg_ready); end
      checks++; if (bus.digest_out !== dig_abc) begin failures++; $display("FAIL hold_digest%0d: got %h want %h", j, bus.digest_out, dig_abc); end
      @(posedge clk); #1;
    end
    bus.msg_valid = 1'b0;
    bus.digest_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
    checks++; if (bus.digest_valid !== 1'b0 || bus.msg_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL hold_release: got valid=%b ready=%b busy=%b want 0/1/0", bus.digest_valid, bus.msg_ready, bus.busy); end
    checks++; if (bus.digest_out !== dig_abc) begin failures++; $display("FAIL hold_retain: got %h want %h", bus.digest_out, dig_abc); end
  endtask
  task automatic test_reset_mid();
    logic [127:0] dig;
    int lat;
    bus.msg_in = abc_blk; bus.chain_in = iv; bus.msg_valid = 1'b1;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.msg_ready !== 1'b1 || bus.digest_valid !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got busy=%b ready=%b valid=%b want 0/1/0", bus.busy, bus.msg_ready, bus.digest_valid); end
    checks++; if (bus.digest_out !== '0) begin failures++; $display("FAIL midrst_digest: got %h want 0", bus.digest_out); end
    checks++; if ({bus.rnd_a, bus.rnd_b, bus.rnd_c, bus.rnd_d, bus.rnd_m, bus.rnd_t} !== '0) begin failures++; $display("FAIL midrst_rnd: got %h want 0", {bus.rnd_a, bus.rnd_b, bus.rnd_c, bus.rnd_d}); end
    bus.msg_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_accept_in_reset: got %b want 0", bus.busy); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_first_edge_accept: got %b want 1", bus.busy); end
    wait_digest(dig, lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL midrst_latency: got %0d want 65", lat); end
    checks++; if (dig !== dig_abc) begin failures++; $display("FAIL midrst_digest_abc: got %h want %h", dig, dig_abc); end
  endtask
  task automatic test_back_to_back();
    logic [511:0] m1, m2;
    logic [127:0] c1, d1, d2;
    int v1, acc2, v2, cyc;
    m1 = rand_blk(); m2 = rand_blk();
    c1 = iv;
    d1 = md5_ref(m1, c1);
    d2 = md5_ref(m2, d1);
    v1 = -1; acc2 = -1; v2 = -1;
    bus.digest_ready = 1'b1;
    bus.msg_in = m1; bus.chain_in = c1; bus.msg_valid = 1'b1;
    @(posedge clk); #1;
    bus.msg_in = m2; bus.chain_in = d1;
    cyc = 0;
    while (v2 < 0 && cyc < 300) begin
      if (bus.msg_valid && bus.msg_ready) begin acc2 = cyc + 1; end
      @(posedge clk); #1;
      cyc++;
      if (acc2 > 0) bus.msg_valid = 1'b0;
      if (bus.digest_valid && v1 < 0) begin
        v1 = cyc;
        checks++; if (bus.digest_out !== d1) begin failures++; $display("FAIL b2b_digest1: got %h want %h", bus.digest_out, d1); end
      end else if (bus.digest_valid && v1 >= 0) begin
        v2 = cyc;
        checks++; if (bus.digest_out !== d2) begin failures++; $display("FAIL b2b_digest2: got %h want %h", bus.digest_out, d2); end
      end
    end
    bus.msg_valid = 1'b0;
    @(posedge clk); #1;
    bus.digest_ready = 1'b0;
    checks++; if (v1 !== 65) begin failures++; $display("FAIL b2b_valid1_cycle: got %0d want 65", v1); end
    checks++; if (acc2 !== 67) begin failures++; $display("FAIL b2b_accept2_cycle: got %0d want 67", acc2); end
    checks++; if (v2 !== 132) begin failures++; $display("FAIL b2b_valid2_cycle: got %0d want 132", v2); end
  endtask
  task automatic test_random();
    logic [511:0] m;
    logic [127:0] ch, dig;
    int lat;
    for (int n = 0; n < 4; n++) begin
      m = rand_blk();
      ch = {$urandom, $urandom, $urandom, $urandom};
      send_block(m, ch, dig, lat);
      checks++; if (lat !== 65) begin failures++; $display("FAIL rand%0d_latency: got %0d want 65", n, lat); end
      checks++; if (dig !== md5_ref(m, ch)) begin failures++; $display("FAIL rand%0d_digest: got %h want %h", n, dig, md5_ref(m, ch)); end
    end
  endtask
  initial begin
    bus.msg_in = '0; bus.chain_in = '0; bus.msg_valid = 1'b0; bus.digest_ready = 1'b0;
    abc_blk = '0;
    abc_blk[31:0] = 32'h80636261;
    abc_blk[14 * 32 +: 32] = 32'h18;
    test_reset();
    test_vectors();
    test_steps();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pancham_step_sequencer.md
PANCHAM_STEP_SEQUENCER -- requirements
Module: pancham_step_sequencer

Interface
REQ-001 SHALL have ports: clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: msg_in, input, 512, one padded block; word k = msg_in[32k+31:32k], already little-endian per RFC1321.
REQ-004 SHALL have ports: chain_in, input, 128, chaining value {D,C,B,A}, A in [31:0]; sampled with msg_in.
REQ-005 SHALL have ports: msg_valid, input, 1, block offered; msg_ready, output, 1, block accepted when both high.
REQ-006 SHALL have ports: rnd_a/rnd_b/rnd_c/rnd_d/rnd_m/rnd_s/rnd_t, output, 32 each, operands to the external round unit.
REQ-007 SHALL have ports: rnd_round, output, 2, round 1-4 encoded 2'b00-2'b11.
REQ-008 SHALL have ports: rnd_next_a, input, 32, combinational result from the round unit.
REQ-009 SHALL have ports: digest_out, output, 128, {D,C,B,A} result; digest_valid, output, 1; digest_ready, input, 1.
REQ-010 SHALL have ports: busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, ROUND, FINAL, DONE; msg_ready = 1 only in IDLE.
REQ-012 SHALL, on msg_valid&&msg_ready edge, register msg_in, chain_in, load (a,b,c,d) from chain_in, clear 6-bit step counter, enter ROUND.
REQ-013 SHALL ignore msg_valid in every state except IDLE; msg_in changes while busy have no effect.
REQ-014 SHALL in ROUND drive rnd_a..rnd_d from working registers, rnd_round = step[5:4], rnd_t = T[step], rnd_s = S[step], rnd_m = word[k].
REQ-015 SHALL compute k: round1 k=i; round2 k=(5i+1) mod 16; round3 k=(3i+5) mod 16; round4 k=7i mod 16 (i = step).
REQ-016 SHALL use shift table per round, cycling by step[1:0]: {7,12,17,22}, {5,9,14,20}, {4,11,16,23}, {6,10,15,21}; rnd_s zero-extended to 32 bits.
REQ-017 SHALL hold T[i] = floor(abs(sin(i+1))*2^32), i=0..63, as constant table (T[0]=32'hd76aa478, T[63]=32'heb86d391).
REQ-018 SHALL at each ROUND edge update (a,b,c,d) <= (d, rnd_next_a, b, c) and increment step; one MD5 step per cycle.
REQ-019 SHALL go ROUND->FINAL on the edge where step==63 (wrap to 0 not used); 64 ROUND cycles exactly.
REQ-020 SHALL in FINAL register digest_out = per-word chain + {d,c,b,a}, each add mod 2^32, no carry between words; enter DONE with digest_valid=1.
REQ-021 SHALL hold digest_valid and digest_out stable in DONE until digest_ready=1; on that edge go to IDLE, digest_valid=0, digest_out retains value.
REQ-022 SHALL give latency: digest_valid rises 65 cycles after the accept edge; with digest_ready tied high, next block accepted no earlier than 67 cycles after previous accept.
REQ-023 SHALL drive rnd_m, rnd_s, rnd_t to 0 outside ROUND; rnd_round = step[5:4] always.
REQ-024 SHALL treat digest_ready high outside DONE as no-op.

Reset
REQ-025 SHALL on reset_n low immediately, regardless of state: state=IDLE, step=0, a/b/c/d=0, digest_out=0, digest_valid=0, busy=0, msg_ready=1 after release.
REQ-026 SHALL abort an in-progress block on reset mid-ROUND/FINAL/DONE; no partial digest_valid pulse after release.
REQ-027 SHALL accept msg_valid on first rising edge after reset_n deassertion.

Verification
REQ-028 SHALL cover: chain_in=IV (A=67452301,B=efcdab89,C=98badcfe,D=10325476), msg_in=512'h80 (empty msg) -> digest_out=128'h7e42f8ec_980980e9_04b2008f_d98c1dd4 at cycle 65.
REQ-029 SHALL cover: IV, word0=32'h80636261, word14=32'h18, rest 0 ("abc") -> digest_out=128'h727fe128_7d3f96d6_b04fd23c_98500190.
REQ-030 SHALL cover: digest_ready held low 10 cycles in DONE -> digest_valid and digest_out stable; msg_valid pulses during busy ignored (msg_ready=0).
REQ-031 SHALL cover: reset_n asserted at step 30 -> outputs zero at once, state IDLE; new "abc" block afterward gives REQ-029 digest.
REQ-032 SHALL cover: step-by-step check of rnd_round, rnd_s, rnd_t, k for steps 0,16,17,32,33,48,49,63 (e.g., step 17: round=1, k=6, s=9, t=32'hc040b340).
REQ-033 SHALL cover: two back-to-back blocks with digest_ready high, second chain_in = first digest -> matches reference model MD5 of two-block message.
